block_mul_scheduler: RTL

// - Shares NUM_UNITS 2x2 block-multiply units between a matrix controller's stream of block jobs.
// - Accepts jobs (A and B blocks, 4 words each), grants a free unit round-robin and tracks it.
// - Returns 2x2 results strictly in job-acceptance order, whatever order the units finish in.
// - Sits between the matrix-multiply sequencer FSM and the unit array.

---
 rtl/mul_sched_pkg.sv | 26 ++
 rtl/unit_order_fifo.sv | 58 +++++
 rtl/block_mul_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mul_sched_pkg.sv
// Shared constants and sizing helpers for the block-multiply scheduler.
// Blocks pack four words as {downRight, downLeft, upRight, upLeft}.
package mul_sched_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_UNITS_DEF  = 3;
  localparam int BLK_WORDS      = 4;
  localparam int BLK_W          = BLK_WORDS * DATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    UL = 2'd0,
    UR = 2'd1,
    DL = 2'd2,
    DR = 2'd3
  } word_pos_e;

  function automatic int blk_w(input int data_width);
    return BLK_WORDS * data_width;
  endfunction

  // Width of a unit index; never zero, even for the smallest legal unit count.
  function automatic int unit_idx_w(input int num_units);
    return (num_units <= 2) ? 1 : $clog2(num_units);
  endfunction

endpackage

// File: rtl/unit_order_fifo.sv
// Synchronous FIFO of unit indices, in grant order, so results retire in job-acceptance order.
// The owner guarantees no push when full and no pop when empty.
module unit_order_fifo
  import mul_sched_pkg::*;
#(
  parameter int DEPTH = NUM_UNITS_DEF,
  parameter int W     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int               PTR_W = unit_idx_w(DEPTH);
  localparam int               CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      // NOTE: this tiny array is reset so the head index (and the result it selects) is never X out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= bump(wr_q);
      end
      if (pop) rd_q <= bump(rd_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/block_mul_scheduler.sv
// Schedules 2x2 block-multiply jobs onto NUM_UNITS shared units with round-robin grant,
// and returns results strictly in job-acceptance order regardless of unit finish order.
module block_mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_UNITS  = NUM_UNITS_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              job_valid,
  output logic                              job_ready,
  input  logic [4*DATA_WIDTH-1:0]           job_a,
  input  logic [4*DATA_WIDTH-1:0]           job_b,
  output logic [NUM_UNITS-1:0]              unit_start,
  output logic [4*DATA_WIDTH-1:0]           unit_a,
  output logic [4*DATA_WIDTH-1:0]           unit_b,
  input  logic [NUM_UNITS-1:0]              unit_done,
  input  logic [NUM_UNITS*4*DATA_WIDTH-1:0] unit_result,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [4*DATA_WIDTH-1:0]           res_data,
  output logic [$clog2(NUM_UNITS+1)-1:0]    in_flight,
  output logic                              protocol_err
);

  localparam int               SLOT_W   = blk_w(DATA_WIDTH);
  localparam int               IDX_W    = unit_idx_w(NUM_UNITS);
  localparam int               CNT_W    = $clog2(NUM_UNITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

  logic [NUM_UNITS-1:0] alloc_q, alloc_d;
  logic [NUM_UNITS-1:0] done_q, done_d;
  logic [SLOT_W-1:0]    result_q [NUM_UNITS];
  logic [SLOT_W-1:0]    result_d [NUM_UNITS];
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [NUM_UNITS-1:0] start_q, start_d;
  logic [SLOT_W-1:0]    unit_a_q, unit_a_d;
  logic [SLOT_W-1:0]    unit_b_q, unit_b_d;
  logic                 err_q, err_d;

  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand;
  logic                 accept;
  logic                 pop;
  logic [IDX_W-1:0]     head_idx;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  // Round-robin: first free slot at or after rr_q, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % NUM_UNITS);
      if (!grant_found && !alloc_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign job_ready = |(~alloc_q);
  assign accept    = job_valid && job_ready;
  assign res_valid = !fifo_empty && done_q[head_idx];
  assign res_data  = result_q[head_idx];
  assign pop       = res_valid && res_ready;

  always_comb begin
    alloc_d  = alloc_q;
    done_d   = done_q;
    result_d = result_q;
    err_d    = err_q;
    rr_d     = rr_q;
    start_d  = '0;
    unit_a_d = unit_a_q;
    unit_b_d = unit_b_q;

    // A completion is only legal on an allocated slot still waiting for its result.
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (unit_done[i]) begin
        if (alloc_q[i] && !done_q[i]) begin
          done_d[i]   = 1'b1;
          result_d[i] = unit_result[i*SLOT_W +: SLOT_W];
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (pop) begin
      alloc_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
    end

    // The granted slot is free, so it can never be the slot being retired this cycle.
    if (accept) begin
      alloc_d[grant_idx] = 1'b1;
      start_d[grant_idx] = 1'b1;
      unit_a_d           = job_a;
      unit_b_d           = job_b;
      rr_d               = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      alloc_q  <= '0;
      done_q   <= '0;
      rr_q     <= '0;
      start_q  <= '0;
      unit_a_q <= '0;
      unit_b_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) result_q[i] <= '0;
    end else begin
      alloc_q  <= alloc_d;
      done_q   <= done_d;
      rr_q     <= rr_d;
      start_q  <= start_d;
      unit_a_q <= unit_a_d;
      unit_b_q <= unit_b_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  unit_order_fifo #(
    .DEPTH (NUM_UNITS),
    .W     (IDX_W)
  ) u_order (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (grant_idx),
    .pop       (pop),
    .head      (head_idx),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign unit_start   = start_q;
  assign unit_a       = unit_a_q;
  assign unit_b       = unit_b_q;
  assign in_flight    = fifo_count;
  assign protocol_err = err_q;

endmodule
